// File: rtl/param_tensor_cpu.sv
`default_nettype none
// ============================================================================
//  Module   : param_tensor_cpu
//  Purpose  : Scalar CPU plus tensor core. Decodes one 32-bit instruction per
//             accepted handshake, runs single-cycle ALU ops on a CPU register
//             file, and keeps a 2-bank DIMxDIM tensor register file. A
//             multi-cycle matrix multiply computes bank0 x bank1 one element
//             per cycle into a shadow buffer, then commits it into bank0.
//  Ports    :
//    clock_in               - clock, all state updates on posedge
//    reset_in               - asynchronous active-high reset
//    instruction_in[31:0]   - [31:24] dst, [23:16] src1/imm, [15:8] src2/imm,
//                             [7:0] opcode
//    instruction_valid_in   - instruction_in is valid
//    instruction_ready_out  - instruction accepted this cycle when valid
//    cpu_output             - registered result of the last producing op
//    cpu_output_valid_out   - one-cycle pulse when cpu_output is updated
//    status_out[4:0]        - {parity, overflow, carry, zero, sign}
//    tensor_busy_out        - matrix multiply in progress
//    tensor_done_out        - one-cycle pulse after bank0 commit
//    tensor_core_result     - bank0 flattened, element i*DIM+j
//  Revision : 1.0 - initial release
// ============================================================================
module param_tensor_cpu #(
  parameter int DATA_WIDTH = 8,
  parameter int CPU_REGS   = 8,
  parameter int DIM        = 4,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                             clock_in,
  input  logic                             reset_in,
  input  logic [31:0]                      instruction_in,
  input  logic                             instruction_valid_in,
  output logic                             instruction_ready_out,
  output logic [DATA_WIDTH-1:0]            cpu_output,
  output logic                             cpu_output_valid_out,
  output logic [4:0]                       status_out,
  output logic                             tensor_busy_out,
  output logic                             tensor_done_out,
  output logic [DIM*DIM*DATA_WIDTH-1:0]    tensor_core_result
);

  localparam int c_NEL   = DIM * DIM;
  localparam int c_TREGS = 2 * c_NEL;
  localparam int c_CAW   = (CPU_REGS > 1) ? $clog2(CPU_REGS) : 1;
  localparam int c_TAW   = $clog2(c_TREGS);
  localparam int c_EW    = $clog2(c_NEL);
  localparam int c_ACCW  = 2 * DATA_WIDTH + $clog2(DIM);
  localparam int c_MSB   = DATA_WIDTH - 1;

  localparam logic signed [c_ACCW-1:0] c_SMAX = c_ACCW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [c_ACCW-1:0] c_SMIN = ~c_SMAX;

  localparam logic [7:0] c_OP_ADD    = 8'd0;
  localparam logic [7:0] c_OP_SUB    = 8'd1;
  localparam logic [7:0] c_OP_MUL    = 8'd2;
  localparam logic [7:0] c_OP_EQL    = 8'd3;
  localparam logic [7:0] c_OP_GRT    = 8'd4;
  localparam logic [7:0] c_OP_TC     = 8'd5;
  localparam logic [7:0] c_OP_TCLD   = 8'd6;
  localparam logic [7:0] c_OP_CPU2TC = 8'd7;
  localparam logic [7:0] c_OP_ADDI   = 8'd9;
  localparam logic [7:0] c_OP_SUBI   = 8'd10;
  localparam logic [7:0] c_OP_MOV    = 8'd11;
  localparam logic [7:0] c_OP_MOVTC  = 8'd12;
  localparam logic [7:0] c_OP_TC2CPU = 8'd13;
  localparam logic [7:0] c_OP_RESET  = 8'd14;
  localparam logic [7:0] c_OP_RDCPU  = 8'd15;
  localparam logic [7:0] c_OP_RDTC   = 8'd16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [c_EW-1:0]         e_q, e_d;
  logic                    done_q, done_d;

  logic [DATA_WIDTH-1:0]   r_q [CPU_REGS];
  logic [DATA_WIDTH-1:0]   t_q [c_TREGS];
  logic [DATA_WIDTH-1:0]   c_q [c_NEL];
  logic [4:0]              status_q;
  logic [DATA_WIDTH-1:0]   out_q;
  logic                    out_vld_q;

  // Instruction fields and decoded addresses
  logic [7:0]              w_dst_f, w_s1_f, w_s2_f, w_opc;
  logic [c_CAW-1:0]        w_rd, w_rs1, w_rs2;
  logic [c_TAW-1:0]        w_td, w_ts1;
  logic [DATA_WIDTH-1:0]   w_imm1, w_imm2;
  logic                    w_accept;

  assign w_dst_f  = instruction_in[31:24];
  assign w_s1_f   = instruction_in[23:16];
  assign w_s2_f   = instruction_in[15:8];
  assign w_opc    = instruction_in[7:0];
  assign w_rd     = w_dst_f[c_CAW-1:0];
  assign w_rs1    = w_s1_f[c_CAW-1:0];
  assign w_rs2    = w_s2_f[c_CAW-1:0];
  // Tensor file size need not be a power of two, so wrap with a true modulo.
  assign w_td     = c_TAW'(int'(w_dst_f) % c_TREGS);
  assign w_ts1    = c_TAW'(int'(w_s1_f) % c_TREGS);
  assign w_accept = instruction_valid_in && (state_q == S_IDLE);

  generate
    if (DATA_WIDTH > 8) begin : g_imm_sext
      assign w_imm1 = {{(DATA_WIDTH - 8){w_s1_f[7]}}, w_s1_f};
      assign w_imm2 = {{(DATA_WIDTH - 8){w_s2_f[7]}}, w_s2_f};
    end else begin : g_imm_trunc
      assign w_imm1 = w_s1_f[DATA_WIDTH-1:0];
      assign w_imm2 = w_s2_f[DATA_WIDTH-1:0];
    end
  endgenerate

  // Scalar ALU
  logic [DATA_WIDTH-1:0]   w_a, w_b, w_res, w_out_val;
  logic [DATA_WIDTH:0]     w_ext;
  logic                    w_c, w_v, w_alu_wr, w_out_en;

  assign w_a = r_q[w_rs1];
  assign w_b = ((w_opc == c_OP_ADDI) || (w_opc == c_OP_SUBI)) ? w_imm2 : r_q[w_rs2];

  always_comb begin
    w_ext = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_opc)
      c_OP_ADD, c_OP_ADDI: begin
        w_ext = {1'b0, w_a} + {1'b0, w_b};
        w_res = w_ext[DATA_WIDTH-1:0];
        w_c   = w_ext[DATA_WIDTH];
        w_v   = (w_a[c_MSB] == w_b[c_MSB]) && (w_res[c_MSB] != w_a[c_MSB]);
      end
      c_OP_SUB, c_OP_SUBI: begin
        // Extra bit of the wrapped difference is the unsigned borrow.
        w_ext = {1'b0, w_a} - {1'b0, w_b};
        w_res = w_ext[DATA_WIDTH-1:0];
        w_c   = w_ext[DATA_WIDTH];
        w_v   = (w_a[c_MSB] != w_b[c_MSB]) && (w_res[c_MSB] != w_a[c_MSB]);
      end
      c_OP_MUL: w_res = w_a * w_b;
      c_OP_EQL: w_res = {{(DATA_WIDTH - 1){1'b0}}, (w_a == w_b)};
      c_OP_GRT: w_res = {{(DATA_WIDTH - 1){1'b0}}, ($signed(w_a) > $signed(w_b))};
      c_OP_MOV: w_res = w_a;
      default:  ;
    endcase
  end

  assign w_alu_wr = (w_opc <= c_OP_GRT) ||
                    (w_opc == c_OP_ADDI) || (w_opc == c_OP_SUBI) || (w_opc == c_OP_MOV);
  assign w_out_en = w_alu_wr || (w_opc == c_OP_TC2CPU) ||
                    (w_opc == c_OP_RDCPU) || (w_opc == c_OP_RDTC);

  always_comb begin
    case (w_opc)
      c_OP_TC2CPU, c_OP_RDTC: w_out_val = t_q[w_ts1];
      c_OP_RDCPU:             w_out_val = w_a;
      default:                w_out_val = w_res;
    endcase
  end

  // CPU register file and status flags
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      for (int k = 0; k < CPU_REGS; k++) r_q[k] <= '0;
      status_q <= '0;
    end else if (w_accept) begin
      if (w_opc == c_OP_RESET) begin
        for (int k = 0; k < CPU_REGS; k++) r_q[k] <= '0;
        status_q <= '0;
      end else if (w_alu_wr) begin
        r_q[w_rd] <= w_res;
        status_q  <= {~^w_res, w_v, w_c, (w_res == '0), w_res[c_MSB]};
      end else if (w_opc == c_OP_TC2CPU) begin
        r_q[w_rd] <= t_q[w_ts1];
      end
    end
  end

  // Result register
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_vld_q <= 1'b0;
      if (w_accept && w_out_en) begin
        out_q     <= w_out_val;
        out_vld_q <= 1'b1;
      end
    end
  end

  // Matrix-multiply datapath: one dot product per cycle, element e_q.
  int                        w_row, w_col;
  logic signed [c_ACCW-1:0]  w_acc, w_pa, w_pb;
  logic [DATA_WIDTH-1:0]     w_elem;

  always_comb begin
    w_row = int'(e_q) / DIM;
    w_col = int'(e_q) % DIM;
    w_acc = '0;
    w_pa  = '0;
    w_pb  = '0;
    for (int k = 0; k < DIM; k++) begin
      w_pa  = c_ACCW'($signed(t_q[c_TAW'(w_row * DIM + k)]));
      w_pb  = c_ACCW'($signed(t_q[c_TAW'(c_NEL + k * DIM + w_col)]));
      w_acc = w_acc + w_pa * w_pb;
    end
  end

  generate
    if (SATURATE) begin : g_sat
      always_comb begin
        if (w_acc > c_SMAX)      w_elem = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        else if (w_acc < c_SMIN) w_elem = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        else                     w_elem = w_acc[DATA_WIDTH-1:0];
      end
    end else begin : g_wrap
      assign w_elem = w_acc[DATA_WIDTH-1:0];
    end
  endgenerate

  // Shadow result buffer; bank0 stays intact until the commit edge.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      for (int k = 0; k < c_NEL; k++) c_q[k] <= '0;
    end else if (state_q == S_COMPUTE) begin
      c_q[e_q] <= w_elem;
    end
  end

  // Tensor register file
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      for (int k = 0; k < c_TREGS; k++) t_q[k] <= '0;
    end else if (state_q == S_COMMIT) begin
      for (int k = 0; k < c_NEL; k++) t_q[k] <= c_q[k];
    end else if (w_accept) begin
      case (w_opc)
        c_OP_TCLD:   t_q[w_td] <= w_imm1;
        c_OP_CPU2TC: t_q[w_td] <= w_a;
        c_OP_MOVTC:  t_q[w_td] <= t_q[w_ts1];
        c_OP_RESET:  for (int k = 0; k < c_TREGS; k++) t_q[k] <= '0;
        default:     ;
      endcase
    end
  end

  // Control FSM
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      e_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_accept && (w_opc == c_OP_TC)) begin
          state_d = S_COMPUTE;
          e_d     = '0;
        end
      end
      S_COMPUTE: begin
        if (e_q == c_EW'(c_NEL - 1)) begin
          state_d = S_COMMIT;
          e_d     = '0;
        end else begin
          e_d = e_q + c_EW'(1);
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign instruction_ready_out = (state_q == S_IDLE);
  assign tensor_busy_out       = (state_q == S_COMPUTE) || (state_q == S_COMMIT);
  assign tensor_done_out       = done_q;
  assign cpu_output            = out_q;
  assign cpu_output_valid_out  = out_vld_q;
  assign status_out            = status_q;

  generate
    for (genvar g = 0; g < c_NEL; g++) begin : g_flat
      assign tensor_core_result[g*DATA_WIDTH +: DATA_WIDTH] = t_q[g];
    end
  endgenerate

endmodule
`default_nettype wire
